decode_stage: RTL and testbench

- RV32I integer decode/issue stage. It is the producing end of the ALU interface.
- Accepts fetched instruction words over a valid/ready handshake and reads the register file.
- Decodes each word into ALU op/alt_op/operands plus writeback info, and presents them in a single skid-free pipeline register to the execute stage.
- Covers the OP, OP-IMM, LUI and AUIPC opcodes. Every other opcode is flagged illegal.

---
 rtl/decode_stage.sv | 186 ++++++++++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into an ALU
// payload held in one valid/ready pipeline register feeding execute.
module decode_stage #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [2:0]      ex_alu_op_o,
  output logic            ex_alt_op_o,
  output logic [XLEN-1:0] ex_operand1_o,
  output logic [XLEN-1:0] ex_operand2_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_wb_en_o,
  output logic            ex_illegal_o,
  output logic [XLEN-1:0] ex_pc_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [2:0]      alu_op;
    logic            alt_op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } payload_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  logic            legal;
  logic [2:0]      alu_op;
  logic            alt_op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;

  payload_t decoded;
  payload_t payload_d, payload_q;
  logic     valid_d, valid_q;
  logic     accept;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign shamt = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    legal    = 1'b0;
    alu_op   = F3_ADD;
    alt_op   = 1'b0;
    operand1 = '0;
    operand2 = '0;

    unique case (opcode)
      OPC_OP: begin
        alu_op   = funct3;
        operand1 = rs1_data_i;
        operand2 = rs2_data_i;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          legal  = 1'b1;
          alt_op = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_op   = funct3;
        operand1 = rs1_data_i;
        if (funct3 == F3_SLL) begin
          operand2 = shamt;
          legal    = (funct7 == F7_BASE);
        end else if (funct3 == F3_SR) begin
          operand2 = shamt;
          alt_op   = instr_i[30];
          legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          // instr[30] is immediate data here, never a SUB select
          operand2 = imm_i;
          legal    = 1'b1;
        end
      end
      OPC_LUI: begin
        operand2 = imm_u;
        legal    = 1'b1;
      end
      OPC_AUIPC: begin
        operand1 = pc_i;
        operand2 = imm_u;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal words travel with a zeroed ALU payload so execute never acts on them.
  always_comb begin
    decoded          = '0;
    decoded.rd       = rd;
    decoded.pc       = pc_i;
    decoded.illegal  = !legal;
    decoded.wb_en    = legal && (rd != 5'd0);
    if (legal) begin
      decoded.alu_op   = alu_op;
      decoded.alt_op   = alt_op;
      decoded.operand1 = operand1;
      decoded.operand2 = operand2;
    end
  end

  assign instr_ready_o = rstn_i && !flush_i && (!valid_q || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      payload_d = decoded;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload fields are reset too, because every ex_* output must read 0 while in reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_alu_op_o   = payload_q.alu_op;
  assign ex_alt_op_o   = payload_q.alt_op;
  assign ex_operand1_o = payload_q.operand1;
  assign ex_operand2_o = payload_q.operand2;
  assign ex_rd_o       = payload_q.rd;
  assign ex_wb_en_o    = payload_q.wb_en;
  assign ex_illegal_o  = payload_q.illegal;
  assign ex_pc_o       = payload_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of decode vectors plus
// hand-written backpressure, flush and asynchronous-reset sequences.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [2:0]  ex_alu_op_o;
  logic        ex_alt_op_o;
  logic [31:0] ex_operand1_o;
  logic [31:0] ex_operand2_o;
  logic [4:0]  ex_rd_o;
  logic        ex_wb_en_o;
  logic        ex_illegal_o;
  logic [31:0] ex_pc_o;

  always #5 clk_i = ~clk_i;

  decode_stage #(.XLEN(32)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .ex_alu_op_o   (ex_alu_op_o),
    .ex_alt_op_o   (ex_alt_op_o),
    .ex_operand1_o (ex_operand1_o),
    .ex_operand2_o (ex_operand2_o),
    .ex_rd_o       (ex_rd_o),
    .ex_wb_en_o    (ex_wb_en_o),
    .ex_illegal_o  (ex_illegal_o),
    .ex_pc_o       (ex_pc_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  alu;
    logic        alt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int total;
  int bad;

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] rs1,
                              logic [31:0] rs2, logic [2:0] alu, logic alt,
                              logic [31:0] op1, logic [31:0] op2, logic [4:0] rd,
                              logic wb, logic ill);
    vec_t v;
    v.instr = instr; v.pc  = pc;  v.rs1 = rs1; v.rs2 = rs2;
    v.alu   = alu;   v.alt = alt; v.op1 = op1; v.op2 = op2;
    v.rd    = rd;    v.wb  = wb;  v.ill = ill;
    return v;
  endfunction

  // {valid, alu_op, alt, op1, op2, rd, wb_en, illegal, pc}
  function automatic logic [107:0] act_f();
    return {ex_valid_o, ex_alu_op_o, ex_alt_op_o, ex_operand1_o, ex_operand2_o,
            ex_rd_o, ex_wb_en_o, ex_illegal_o, ex_pc_o};
  endfunction

  function automatic logic [107:0] exp_f(vec_t v);
    return {1'b1, v.alu, v.alt, v.op1, v.op2, v.rd, v.wb, v.ill, v.pc};
  endfunction

  task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    instr_i       = v.instr;
    pc_i          = v.pc;
    rs1_data_i    = v.rs1;
    rs2_data_i    = v.rs2;
    instr_valid_i = valid;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn_i        = 1'b0;
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    ex_ready_i    = 1'b0;
    instr_i       = '0;
    pc_i          = '0;
    rs1_data_i    = '0;
    rs2_data_i    = '0;

    //           instr         pc            rs1           rs2           alu   alt  op1           op2           rd  wb ill
    vecs[0]  = mk(32'h002081B3, 32'h00001000, 32'd5,        32'd7,        3'd0, 1'b0, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0);
    vecs[1]  = mk(32'h407302B3, 32'h00001004, 32'd10,       32'd3,        3'd0, 1'b1, 32'd10,       32'd3,        5'd5, 1'b1, 1'b0);
    vecs[2]  = mk(32'hFFF00093, 32'h00001008, 32'd0,        32'h55,       3'd0, 1'b0, 32'd0,        32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
    vecs[3]  = mk(32'h40415113, 32'h0000100C, 32'h80000000, 32'h1234,     3'd5, 1'b1, 32'h80000000, 32'd4,        5'd2, 1'b1, 1'b0);
    vecs[4]  = mk(32'h40411113, 32'h00001010, 32'h80000000, 32'd1,        3'd0, 1'b0, 32'd0,        32'd0,        5'd2, 1'b0, 1'b1);
    vecs[5]  = mk(32'h00000013, 32'h00001014, 32'd0,        32'd0,        3'd0, 1'b0, 32'd0,        32'd0,        5'd0, 1'b0, 1'b0);
    vecs[6]  = mk(32'h00000000, 32'h00001018, 32'hAAAA,     32'hBBBB,     3'd0, 1'b0, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1);
    vecs[7]  = mk(32'h12345237, 32'h0000101C, 32'hDEAD,     32'hBEEF,     3'd0, 1'b0, 32'd0,        32'h12345000, 5'd4, 1'b1, 1'b0);
    vecs[8]  = mk(32'h00001317, 32'h00000100, 32'h77,       32'h88,       3'd0, 1'b0, 32'h100,      32'h1000,     5'd6, 1'b1, 1'b0);
    vecs[9]  = mk(32'h400040B3, 32'h00001020, 32'd1,        32'd2,        3'd0, 1'b0, 32'd0,        32'd0,        5'd1, 1'b0, 1'b1);
    vecs[10] = mk(32'h40000093, 32'h00001024, 32'd7,        32'd0,        3'd0, 1'b0, 32'd7,        32'h400,      5'd1, 1'b1, 1'b0);
    vecs[11] = mk(32'h01F0D193, 32'h00001028, 32'hF0,       32'd0,        3'd5, 1'b0, 32'hF0,       32'd31,       5'd3, 1'b1, 1'b0);
    vecs[12] = mk(32'h0041B133, 32'h0000102C, 32'd3,        32'd9,        3'd3, 1'b0, 32'd3,        32'd9,        5'd2, 1'b1, 1'b0);
    vecs[13] = mk(32'h020003B3, 32'h00001030, 32'd1,        32'd2,        3'd0, 1'b0, 32'd0,        32'd0,        5'd7, 1'b0, 1'b1);
    vecs[14] = mk(32'h4020D1B3, 32'h00001034, 32'hFFFFFFF8, 32'd2,        3'd5, 1'b1, 32'hFFFFFFF8, 32'd2,        5'd3, 1'b1, 1'b0);
    vecs[15] = mk(32'h4200D093, 32'h00001038, 32'd9,        32'd0,        3'd0, 1'b0, 32'd0,        32'd0,        5'd1, 1'b0, 1'b1);

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_payload", act_f(), '0);
    check("reset_ready", {107'd0, instr_ready_o}, '0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Table: one instruction per cycle with execute always ready.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      ex_ready_i = 1'b1;
      drive(vecs[i], 1'b1);
      #1;
      check($sformatf("rf_addr_%0d", i), {98'd0, rs1_addr_o, rs2_addr_o},
            {98'd0, vecs[i].instr[19:15], vecs[i].instr[24:20]});
      check($sformatf("ready_%0d", i), {107'd0, instr_ready_o}, {107'd0, 1'b1});
      @(posedge clk_i);
      #1;
      check($sformatf("vec_%0d", i), act_f(), exp_f(vecs[i]));
    end
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("drain_valid", {107'd0, ex_valid_o}, '0);

    // Backpressure: A accepted, B waits three stalled cycles, then B follows once.
    @(negedge clk_i);
    ex_ready_i = 1'b0;
    drive(vecs[0], 1'b1);
    @(posedge clk_i);
    #1;
    check("bp_first", act_f(), exp_f(vecs[0]));
    @(negedge clk_i);
    drive(vecs[7], 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_low_%0d", k), {107'd0, instr_ready_o}, '0);
      @(posedge clk_i);
      #1;
      check($sformatf("bp_hold_%0d", k), act_f(), exp_f(vecs[0]));
      @(negedge clk_i);
    end
    ex_ready_i = 1'b1;
    #1;
    check("bp_ready_high", {107'd0, instr_ready_o}, {107'd0, 1'b1});
    @(posedge clk_i);
    #1;
    check("bp_second", act_f(), exp_f(vecs[7]));
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("bp_no_dup", {107'd0, ex_valid_o}, '0);

    // Flush during a stall drops the payload and refuses the incoming word.
    @(negedge clk_i);
    ex_ready_i = 1'b0;
    drive(vecs[1], 1'b1);
    @(posedge clk_i);
    #1;
    check("fl_load", act_f(), exp_f(vecs[1]));
    @(negedge clk_i);
    drive(vecs[2], 1'b1);
    flush_i = 1'b1;
    #1;
    check("fl_ready_low", {107'd0, instr_ready_o}, '0);
    @(posedge clk_i);
    #1;
    check("fl_valid_low", {107'd0, ex_valid_o}, '0);
    @(negedge clk_i);
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("fl_not_accepted", {107'd0, ex_valid_o}, '0);

    // Asynchronous reset in the middle of a stall clears outputs before any edge.
    @(negedge clk_i);
    ex_ready_i = 1'b0;
    drive(vecs[3], 1'b1);
    @(posedge clk_i);
    #1;
    check("ar_load", act_f(), exp_f(vecs[3]));
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    @(posedge clk_i);
    #3;
    rstn_i = 1'b0;
    #1;
    check("ar_payload", act_f(), '0);
    check("ar_ready", {107'd0, instr_ready_o}, '0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ar_after", {107'd0, ex_valid_o}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
